// File: rtl/ecc_mem_scrubber_if.sv
`default_nettype none
// ============================================================================
// ecc_mem_scrubber_if : single-port request/grant memory bus for the scrubber
// Revision 1.0
// ============================================================================
interface ecc_mem_scrubber_if #(
  parameter int ADDR_W = 8,
  parameter int CW_W   = 13
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [CW_W-1:0]   wdata;
  logic              gnt;
  logic              rvalid;
  logic [CW_W-1:0]   rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface
`default_nettype wire

// File: rtl/ecc_mem_scrubber.sv
`default_nettype none
// ============================================================================
// ecc_mem_scrubber : background SECDED scrubber, read/check/rewrite each word
// Revision 1.0
// ============================================================================
module ecc_mem_scrubber #(
  parameter int K      = 8,
  parameter int M      = 4,
  parameter int CW_W   = K + M + 1,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  output logic               busy_o,
  output logic               done_o,
  ecc_mem_scrubber_if.master mem,
  output logic [CW_W-1:0]    dec_cw_o,
  input  logic [K-1:0]       dec_data_i,
  input  logic               dec_sb_err_i,
  input  logic               dec_db_err_i,
  output logic [K-1:0]       enc_data_o,
  input  logic [CW_W-1:0]    enc_cw_i,
  output logic [CNT_W-1:0]   sb_cnt_o,
  output logic [CNT_W-1:0]   db_cnt_o,
  output logic               db_flag_o,
  output logic [ADDR_W-1:0]  db_addr_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD    = 3'd1;
  localparam logic [2:0] S_RWAIT = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_WR    = 3'd4;
  localparam logic [2:0] S_ADV   = 3'd5;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  if (2**M < M + K + 1) begin : g_bad_parity_width
    $error("ecc_mem_scrubber: M too small for K");
  end
  if (DEPTH > 2**ADDR_W) begin : g_bad_addr_width
    $error("ecc_mem_scrubber: DEPTH does not fit in ADDR_W");
  end

  logic [2:0]        state_q,    state_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic [CW_W-1:0]   dec_cw_q,   dec_cw_d;
  logic [K-1:0]      enc_data_q, enc_data_d;
  logic [CNT_W-1:0]  sb_cnt_q,   sb_cnt_d;
  logic [CNT_W-1:0]  db_cnt_q,   db_cnt_d;
  logic              db_flag_q,  db_flag_d;
  logic [ADDR_W-1:0] db_addr_q,  db_addr_d;
  logic              last_addr;

  assign last_addr = (addr_q == LAST_ADDR);

  // State register and datapath flops
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      dec_cw_q   <= '0;
      enc_data_q <= '0;
      sb_cnt_q   <= '0;
      db_cnt_q   <= '0;
      db_flag_q  <= 1'b0;
      db_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      dec_cw_q   <= dec_cw_d;
      enc_data_q <= enc_data_d;
      sb_cnt_q   <= sb_cnt_d;
      db_cnt_q   <= db_cnt_d;
      db_flag_q  <= db_flag_d;
      db_addr_q  <= db_addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i)    state_d = S_RD;
      S_RD:    if (mem.gnt)    state_d = S_RWAIT;
      S_RWAIT: if (mem.rvalid) state_d = S_CHECK;
      S_CHECK: state_d = (!dec_db_err_i && dec_sb_err_i) ? S_WR : S_ADV;
      S_WR:    if (mem.gnt)    state_d = S_ADV;
      S_ADV:   state_d = last_addr ? S_IDLE : S_RD;
      default: state_d = S_IDLE;
    endcase
  end

  // An uncorrectable error wins over sb when the decoder raises both flags
  always_comb begin
    addr_d     = addr_q;
    dec_cw_d   = dec_cw_q;
    enc_data_d = enc_data_q;
    sb_cnt_d   = sb_cnt_q;
    db_cnt_d   = db_cnt_q;
    db_flag_d  = db_flag_q;
    db_addr_d  = db_addr_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          addr_d    = '0;
          sb_cnt_d  = '0;
          db_cnt_d  = '0;
          db_flag_d = 1'b0;
          db_addr_d = '0;
        end
      end
      S_RWAIT: begin
        if (mem.rvalid) dec_cw_d = mem.rdata;
      end
      S_CHECK: begin
        if (dec_db_err_i) begin
          db_cnt_d = (&db_cnt_q) ? db_cnt_q : db_cnt_q + CNT_ONE;
          if (!db_flag_q) begin
            db_flag_d = 1'b1;
            db_addr_d = addr_q;
          end
        end else if (dec_sb_err_i) begin
          sb_cnt_d   = (&sb_cnt_q) ? sb_cnt_q : sb_cnt_q + CNT_ONE;
          enc_data_d = dec_data_i;
        end
      end
      S_ADV: begin
        if (!last_addr) addr_d = addr_q + ADDR_ONE;
      end
      default: ;
    endcase
  end

  // Write data comes from the encoder fed by the registered enc_data_q,
  // so it stays stable for as long as the write waits for a grant.
  always_comb begin
    busy_o    = 1'b0;
    done_o    = 1'b0;
    mem.req   = 1'b0;
    mem.we    = 1'b0;
    mem.addr  = addr_q;
    mem.wdata = '0;
    case (state_q)
      S_RD: begin
        busy_o  = 1'b1;
        mem.req = 1'b1;
      end
      S_RWAIT, S_CHECK: begin
        busy_o = 1'b1;
      end
      S_WR: begin
        busy_o    = 1'b1;
        mem.req   = 1'b1;
        mem.we    = 1'b1;
        mem.wdata = enc_cw_i;
      end
      S_ADV: begin
        busy_o = !last_addr;
        done_o = last_addr;
      end
      default: ;
    endcase
  end

  assign dec_cw_o   = dec_cw_q;
  assign enc_data_o = enc_data_q;
  assign sb_cnt_o   = sb_cnt_q;
  assign db_cnt_o   = db_cnt_q;
  assign db_flag_o  = db_flag_q;
  assign db_addr_o  = db_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_ecc_mem_scrubber.sv
`default_nettype none
// ============================================================================
// tb_ecc_mem_scrubber : directed bench with memory, hamming encoder/decoder
// Revision 1.0
// ============================================================================
module tb_ecc_mem_scrubber;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start1 = 1'b0;
  logic start2 = 1'b0;
  int   gnt_dly = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  // Positions 1..12 are hamming (parity at 1,2,4,8), bit 0 is overall parity
  function automatic logic [12:0] ham_enc(input logic [7:0] d);
    logic [12:0] c;
    c = '0;
    c[3] = d[0]; c[5] = d[1]; c[6] = d[2]; c[7] = d[3];
    c[9] = d[4]; c[10] = d[5]; c[11] = d[6]; c[12] = d[7];
    c[1] = c[3] ^ c[5] ^ c[7] ^ c[9] ^ c[11];
    c[2] = c[3] ^ c[6] ^ c[7] ^ c[10] ^ c[11];
    c[4] = c[5] ^ c[6] ^ c[7] ^ c[12];
    c[8] = c[9] ^ c[10] ^ c[11] ^ c[12];
    c[0] = ^c[12:1];
    return c;
  endfunction

  // Returns {db, sb, corrected data}
  function automatic logic [9:0] ham_dec(input logic [12:0] cw);
    logic [3:0]  s;
    logic [12:0] c;
    logic        sb;
    logic        db;
    s  = 4'd0;
    c  = cw;
    sb = 1'b0;
    db = 1'b0;
    for (int i = 1; i < 13; i++) if (cw[i]) s = s ^ 4'(i);
    if (^cw) begin
      if (s > 4'd12) db = 1'b1;
      else begin
        sb = 1'b1;
        c[s] = ~c[s];
      end
    end else if (s != 4'd0) db = 1'b1;
    return {db, sb, c[12], c[11], c[10], c[9], c[7], c[6], c[5], c[3]};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- DUT 1: DEPTH=4, CNT_W=16 ----------------
  ecc_mem_scrubber_if #(.ADDR_W(8), .CW_W(13)) m1 ();
  logic        busy1, done1, sb_e1, db_e1, flag1;
  logic [12:0] dec_cw1, enc_cw1;
  logic [7:0]  dec_data1, enc_data1, dbaddr1;
  logic [15:0] sbc1, dbc1;
  logic [9:0]  dr1;

  assign dr1       = ham_dec(dec_cw1);
  assign dec_data1 = dr1[7:0];
  assign sb_e1     = dr1[8];
  assign db_e1     = dr1[9];
  assign enc_cw1   = ham_enc(enc_data1);

  ecc_mem_scrubber #(.K(8), .M(4), .CW_W(13), .DEPTH(4), .ADDR_W(8), .CNT_W(16)) u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start1), .busy_o(busy1), .done_o(done1),
    .mem(m1.master), .dec_cw_o(dec_cw1), .dec_data_i(dec_data1),
    .dec_sb_err_i(sb_e1), .dec_db_err_i(db_e1), .enc_data_o(enc_data1),
    .enc_cw_i(enc_cw1), .sb_cnt_o(sbc1), .db_cnt_o(dbc1),
    .db_flag_o(flag1), .db_addr_o(dbaddr1)
  );

  logic [12:0] mem1 [0:3];
  int          gw1 = 0, rd1 = 0, wr1 = 0, unst1 = 0;
  logic        rv1 = 1'b0, pend1 = 1'b0, pwe1 = 1'b0;
  logic [12:0] rdat1 = '0, wd1 = '0;
  logic [7:0]  wa1 = '0, fa1 = '0, pa1 = '0;

  assign m1.gnt    = m1.req && (gw1 >= gnt_dly);
  assign m1.rvalid = rv1;
  assign m1.rdata  = rdat1;

  always @(posedge clk) begin
    rv1 <= 1'b0;
    gw1 <= (m1.req && !m1.gnt) ? gw1 + 1 : 0;
    if (pend1 && (!m1.req || m1.we != pwe1 || m1.addr != pa1)) unst1 <= unst1 + 1;
    pend1 <= m1.req && !m1.gnt;
    pwe1  <= m1.we;
    pa1   <= m1.addr;
    if (start1 && !busy1) begin
      rd1 <= 0; wr1 <= 0; unst1 <= 0;
    end else if (m1.req && m1.gnt) begin
      if (m1.we) begin
        mem1[m1.addr[1:0]] <= m1.wdata;
        wr1 <= wr1 + 1;
        wa1 <= m1.addr;
        wd1 <= m1.wdata;
      end else begin
        rv1   <= 1'b1;
        rdat1 <= mem1[m1.addr[1:0]];
        if (rd1 == 0) fa1 <= m1.addr;
        rd1 <= rd1 + 1;
      end
    end
  end

  // ---------------- DUT 2: DEPTH=6, CNT_W=2 ----------------
  ecc_mem_scrubber_if #(.ADDR_W(8), .CW_W(13)) m2 ();
  logic        busy2, done2, sb_e2, db_e2, flag2;
  logic [12:0] dec_cw2, enc_cw2;
  logic [7:0]  dec_data2, enc_data2, dbaddr2;
  logic [1:0]  sbc2, dbc2;
  logic [9:0]  dr2;

  assign dr2       = ham_dec(dec_cw2);
  assign dec_data2 = dr2[7:0];
  assign sb_e2     = dr2[8];
  assign db_e2     = dr2[9];
  assign enc_cw2   = ham_enc(enc_data2);

  ecc_mem_scrubber #(.K(8), .M(4), .CW_W(13), .DEPTH(6), .ADDR_W(8), .CNT_W(2)) u_dut_sat (
    .clk_i(clk), .rst_i(rst), .start_i(start2), .busy_o(busy2), .done_o(done2),
    .mem(m2.master), .dec_cw_o(dec_cw2), .dec_data_i(dec_data2),
    .dec_sb_err_i(sb_e2), .dec_db_err_i(db_e2), .enc_data_o(enc_data2),
    .enc_cw_i(enc_cw2), .sb_cnt_o(sbc2), .db_cnt_o(dbc2),
    .db_flag_o(flag2), .db_addr_o(dbaddr2)
  );

  logic [12:0] mem2 [0:5];
  int          gw2 = 0, wr2 = 0;
  logic        rv2 = 1'b0;
  logic [12:0] rdat2 = '0;

  assign m2.gnt    = m2.req && (gw2 >= gnt_dly);
  assign m2.rvalid = rv2;
  assign m2.rdata  = rdat2;

  always @(posedge clk) begin
    rv2 <= 1'b0;
    gw2 <= (m2.req && !m2.gnt) ? gw2 + 1 : 0;
    if (start2 && !busy2) wr2 <= 0;
    else if (m2.req && m2.gnt) begin
      if (m2.we) begin
        mem2[m2.addr[2:0]] <= m2.wdata;
        wr2 <= wr2 + 1;
      end else begin
        rv2   <= 1'b1;
        rdat2 <= mem2[m2.addr[2:0]];
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic run_pass(input bit sel, input int mid_start, output int cyc);
    @(posedge clk); #1;
    if (sel) start2 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    start2 = 1'b0;
    cyc = 1;
    while (!(sel ? done2 : done1) && cyc < 400) begin
      if (!sel) start1 = (cyc == mid_start);
      @(posedge clk); #1;
      cyc++;
    end
    start1 = 1'b0;
  endtask

  task automatic load_clean();
    mem1[0] = ham_enc(8'h3C);
    mem1[1] = ham_enc(8'h00);
    mem1[2] = ham_enc(8'hA5);
    mem1[3] = ham_enc(8'hFF);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int n;
    int seen;

    load_clean();
    for (int i = 0; i < 6; i++) mem2[i] = ham_enc(8'(i * 17)) ^ (13'd1 << (i + 1));

    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_ctrl", {busy1, done1, m1.req, m1.we, m1.addr, m1.wdata}, 64'h0);
    check_eq("reset_data", {dec_cw1, enc_data1, flag1, dbaddr1}, 64'h0);
    check_eq("reset_cnts", {sbc1, dbc1}, 64'h0);
    rst = 1'b0;

    // Clean memory, immediate grant
    run_pass(1'b0, -1, cyc);
    check_eq("clean_done_cyc", 64'(cyc), 64'd16);
    check_eq("clean_reads", 64'(rd1), 64'd4);
    check_eq("clean_writes", 64'(wr1), 64'd0);
    check_eq("clean_sb_cnt", 64'(sbc1), 64'd0);
    check_eq("clean_db_cnt", 64'(dbc1), 64'd0);
    check_eq("clean_db_flag", 64'(flag1), 64'd0);

    // Single-bit error: bit 5 of addr 2 (data 0xA5)
    mem1[2] = ham_enc(8'hA5) ^ 13'h0020;
    run_pass(1'b0, -1, cyc);
    check_eq("sb_done_cyc", 64'(cyc), 64'd17);
    check_eq("sb_writes", 64'(wr1), 64'd1);
    check_eq("sb_wr_addr", 64'(wa1), 64'd2);
    check_eq("sb_wr_data", 64'(wd1), 64'h144E);
    check_eq("sb_enc_data", 64'(enc_data1), 64'hA5);
    check_eq("sb_sb_cnt", 64'(sbc1), 64'd1);
    check_eq("sb_db_flag", 64'(flag1), 64'd0);
    check_eq("sb_mem_fixed", 64'(mem1[2]), 64'h144E);

    run_pass(1'b0, -1, cyc);
    check_eq("rescrub_sb_cnt", 64'(sbc1), 64'd0);
    check_eq("rescrub_writes", 64'(wr1), 64'd0);

    // Double-bit errors at addr 1 and addr 3
    load_clean();
    mem1[1] = ham_enc(8'h00) ^ 13'h0048;
    mem1[3] = ham_enc(8'hFF) ^ 13'h0006;
    run_pass(1'b0, -1, cyc);
    check_eq("db_done_cyc", 64'(cyc), 64'd16);
    check_eq("db_writes", 64'(wr1), 64'd0);
    check_eq("db_db_cnt", 64'(dbc1), 64'd2);
    check_eq("db_sb_cnt", 64'(sbc1), 64'd0);
    check_eq("db_flag", 64'(flag1), 64'd1);
    check_eq("db_addr", 64'(dbaddr1), 64'd1);

    // Grant held off 5 cycles on every request, one correctable word
    load_clean();
    mem1[2] = ham_enc(8'hA5) ^ 13'h0020;
    gnt_dly = 5;
    run_pass(1'b0, -1, cyc);
    gnt_dly = 0;
    check_eq("slow_done_cyc", 64'(cyc), 64'd42);
    check_eq("slow_reads", 64'(rd1), 64'd4);
    check_eq("slow_writes", 64'(wr1), 64'd1);
    check_eq("slow_wr_addr", 64'(wa1), 64'd2);
    check_eq("slow_sb_cnt", 64'(sbc1), 64'd1);
    check_eq("slow_req_stable", 64'(unst1), 64'd0);

    // Reset during RWAIT of addr 1
    load_clean();
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    n = 0;
    while (!(m1.req && m1.gnt && !m1.we && m1.addr == 8'd1) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    check_eq("abort_ctrl", {busy1, done1, m1.req, m1.we, m1.addr, m1.wdata}, 64'h0);
    check_eq("abort_data", {dec_cw1, enc_data1, flag1, dbaddr1}, 64'h0);
    check_eq("abort_cnts", {sbc1, dbc1}, 64'h0);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done1 || busy1) seen++;
    end
    check_eq("abort_quiet", 64'(seen), 64'd0);

    // Restart after abort, with an ignored start pulse mid-pass
    run_pass(1'b0, 5, cyc);
    check_eq("restart_done_cyc", 64'(cyc), 64'd16);
    check_eq("restart_reads", 64'(rd1), 64'd4);
    check_eq("restart_first_addr", 64'(fa1), 64'd0);
    check_eq("restart_writes", 64'(wr1), 64'd0);

    // Saturating 2-bit counter, every word correctable
    run_pass(1'b1, -1, cyc);
    check_eq("sat_done_cyc", 64'(cyc), 64'd30);
    check_eq("sat_sb_cnt", 64'(sbc2), 64'd3);
    check_eq("sat_writes", 64'(wr2), 64'd6);
    check_eq("sat_db_cnt", 64'(dbc2), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
